// File: rtl/pio_sequencer.sv
// Loads a PIO instruction image and per-machine config from registered ROMs,
// then arbitrates round-robin TX-FIFO pushes from four requesters onto the PIO command port.
module pio_sequencer #(
  parameter int         PROG_LEN  = 32,
  parameter int         CONF_LEN  = 10,
  parameter logic [3:0] CONF_MASK = 4'b0011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reload,
  output logic [4:0]   prog_addr,
  input  logic [15:0]  prog_data,
  output logic [1:0]   conf_sm,
  output logic [4:0]   conf_idx,
  input  logic [35:0]  conf_data,
  output logic [3:0]   action,
  output logic [4:0]   index,
  output logic [1:0]   mindex,
  output logic [31:0]  din,
  input  logic [3:0]   tx_full,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   ack,
  output logic         ready,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester holds req/req_data until it sees its one-cycle ack
  // pulse; dropping req before ack withdraws the request.

  typedef enum logic [1:0] {
    ST_PROG = 2'd0,
    ST_CONF = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
  localparam logic [4:0] CONF_LAST = 5'(CONF_LEN - 1);

  state_t      state_q, state_d;
  logic [4:0]  prog_addr_q, prog_addr_d;
  logic [1:0]  conf_sm_q, conf_sm_d;
  logic [4:0]  conf_idx_q, conf_idx_d;
  logic        s1_prog_q, s1_prog_d;
  logic        s1_conf_q, s1_conf_d;
  logic [4:0]  s1_idx_q, s1_idx_d;
  logic [1:0]  s1_m_q, s1_m_d;
  logic [3:0]  action_q, action_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  ack_q, ack_d;
  logic        ready_q, ready_d;
  logic [1:0]  rr_q, rr_d;

  logic [1:0]  first_m, next_m;
  logic        has_next;
  logic [3:0]  elig;
  logic        grant_vld;
  logic [1:0]  grant_i, cand;

  // Lowest configured machine, and the next configured one above conf_sm_q.
  always_comb begin
    first_m  = 2'd0;
    next_m   = conf_sm_q;
    has_next = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (CONF_MASK[i]) begin
        first_m = 2'(i);
        if (i > int'(conf_sm_q)) begin
          has_next = 1'b1;
          next_m   = 2'(i);
        end
      end
    end
  end

  // A machine granted last cycle is masked so its tx_full has time to update.
  always_comb begin
    elig      = req & ~tx_full & ~ack_q;
    grant_vld = 1'b0;
    grant_i   = rr_q;
    cand      = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_i   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    conf_sm_d   = conf_sm_q;
    conf_idx_d  = conf_idx_q;
    s1_prog_d   = 1'b0;
    s1_conf_d   = 1'b0;
    s1_idx_d    = prog_addr_q;
    s1_m_d      = conf_sm_q;
    action_d    = 4'd0;
    index_d     = 5'd0;
    mindex_d    = 2'd0;
    din_d       = 32'd0;
    ack_d       = 4'd0;
    ready_d     = ready_q;
    rr_d        = rr_q;

    // ROM data arrives one cycle after its address; issue it from the tag.
    if (s1_prog_q) begin
      action_d = 4'd1;
      index_d  = s1_idx_q;
      din_d    = {16'h0000, prog_data};
    end else if (s1_conf_q) begin
      action_d = conf_data[35:32];
      din_d    = conf_data[31:0];
      mindex_d = s1_m_q;
    end

    case (state_q)
      ST_PROG: begin
        s1_prog_d = 1'b1;
        if (prog_addr_q == PROG_LAST) begin
          if (CONF_MASK == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_CONF;
            conf_sm_d  = first_m;
            conf_idx_d = 5'd0;
          end
        end else begin
          prog_addr_d = prog_addr_q + 5'd1;
        end
      end
      ST_CONF: begin
        s1_conf_d = 1'b1;
        if (conf_idx_q == CONF_LAST) begin
          if (has_next) begin
            conf_sm_d  = next_m;
            conf_idx_d = 5'd0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          conf_idx_d = conf_idx_q + 5'd1;
        end
      end
      ST_RUN: begin
        if (ready_q) begin
          if (reload) begin
            state_d     = ST_PROG;
            ready_d     = 1'b0;
            prog_addr_d = 5'd0;
            conf_sm_d   = 2'd0;
            conf_idx_d  = 5'd0;
            rr_d        = 2'd0;
          end else if (grant_vld) begin
            action_d       = 4'd4;
            mindex_d       = grant_i;
            din_d          = req_data[32*grant_i +: 32];
            ack_d[grant_i] = 1'b1;
            rr_d           = grant_i + 2'd1;
          end
        end else if (!s1_prog_q && !s1_conf_q) begin
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_PROG;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PROG;
      prog_addr_q <= 5'd0;
      conf_sm_q   <= 2'd0;
      conf_idx_q  <= 5'd0;
      s1_prog_q   <= 1'b0;
      s1_conf_q   <= 1'b0;
      s1_idx_q    <= 5'd0;
      s1_m_q      <= 2'd0;
      action_q    <= 4'd0;
      index_q     <= 5'd0;
      mindex_q    <= 2'd0;
      din_q       <= 32'd0;
      ack_q       <= 4'd0;
      ready_q     <= 1'b0;
      rr_q        <= 2'd0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      conf_sm_q   <= conf_sm_d;
      conf_idx_q  <= conf_idx_d;
      s1_prog_q   <= s1_prog_d;
      s1_conf_q   <= s1_conf_d;
      s1_idx_q    <= s1_idx_d;
      s1_m_q      <= s1_m_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      rr_q        <= rr_d;
    end
  end

  assign prog_addr = prog_addr_q;
  assign conf_sm   = conf_sm_q;
  assign conf_idx  = conf_idx_q;
  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;
  assign ack       = ack_q;
  assign ready     = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pio_sequencer.sv
// Bench for pio_sequencer: registered ROM models, directed load/push/reload/reset
// scenarios, a cycle-stamped expected queue and a monitor that pops on every command.
module tb_pio_sequencer;

  localparam int W = 80;

  logic         clk;
  logic         rst;
  logic         reload;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   tx_full;

  logic [4:0]   prog_addr;
  logic [15:0]  prog_data;
  logic [1:0]   conf_sm;
  logic [4:0]   conf_idx;
  logic [35:0]  conf_data;
  logic [3:0]   action;
  logic [4:0]   index;
  logic [1:0]   mindex;
  logic [31:0]  din;
  logic [3:0]   ack;
  logic         ready;
  logic [1:0]   dbg_state;

  logic [4:0]   prog_addr2;
  logic [15:0]  prog_data2;
  logic [1:0]   conf_sm2;
  logic [4:0]   conf_idx2;
  logic [35:0]  conf_data2;
  logic [3:0]   action2;
  logic [4:0]   index2;
  logic [1:0]   mindex2;
  logic [31:0]  din2;
  logic [3:0]   ack2;
  logic         ready2;
  logic [1:0]   dbg_state2;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_abs = 0;
  int t0 = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  pio_sequencer u_dut (
    .clk(clk), .reset(rst), .reload(reload),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .conf_sm(conf_sm), .conf_idx(conf_idx), .conf_data(conf_data),
    .action(action), .index(index), .mindex(mindex), .din(din),
    .tx_full(tx_full), .req(req), .req_data(req_data),
    .ack(ack), .ready(ready), .dbg_state(dbg_state)
  );

  pio_sequencer #(.PROG_LEN(4), .CONF_LEN(10), .CONF_MASK(4'b0000)) u_dut2 (
    .clk(clk), .reset(rst), .reload(1'b0),
    .prog_addr(prog_addr2), .prog_data(prog_data2),
    .conf_sm(conf_sm2), .conf_idx(conf_idx2), .conf_data(conf_data2),
    .action(action2), .index(index2), .mindex(mindex2), .din(din2),
    .tx_full(4'd0), .req(4'd0), .req_data(128'd0),
    .ack(ack2), .ready(ready2), .dbg_state(dbg_state2)
  );

  // ---------------- ROM models ----------------
  function automatic logic [3:0] conf_act(input logic [1:0] m, input logic [4:0] c);
    if (c == 5'd4) return 4'd0;
    return 4'(int'(c) + 2 * int'(m) + 1);
  endfunction

  function automatic logic [31:0] conf_din(input logic [1:0] m, input logic [4:0] c);
    return 32'hC000_0000 + (32'(m) << 16) + 32'(c);
  endfunction

  always @(posedge clk) begin
    prog_data  <= 16'hA000 + 16'(prog_addr);
    conf_data  <= {conf_act(conf_sm, conf_idx), conf_din(conf_sm, conf_idx)};
    prog_data2 <= 16'hB000 + 16'(prog_addr2);
  end
  assign conf_data2 = 36'd0;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input int c, input logic [3:0] a, input logic [4:0] ix,
                                        input logic [1:0] m, input logic [31:0] d,
                                        input logic [3:0] k, input logic ci);
    return {32'(c), a, ix, m, d, k, ci};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Lands on the falling edge of relative cycle rel.
  task automatic goto(input int rel);
    @(negedge clk);
    while (cyc_abs < t0 + rel) @(negedge clk);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc_abs;
  endtask

  task automatic expect_load();
    int j;
    logic [3:0] a;
    j = 0;
    for (int k = 0; k < 32; k++)
      exp_q.push_back(pack(t0 + k + 2, 4'd1, 5'(k), 2'd0, 32'h0000A000 + 32'(k), 4'd0, 1'b1));
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 10; c++) begin
        a = conf_act(2'(m), 5'(c));
        if (a != 4'd0)
          exp_q.push_back(pack(t0 + 34 + j, a, 5'd0, 2'(m), conf_din(2'(m), 5'(c)), 4'd0, 1'b1));
        j++;
      end
    end
  endtask

  task automatic push_grant(input int rel, input int i);
    exp_q.push_back(pack(t0 + rel, 4'd4, 5'd0, 2'(i), req_data[32*i +: 32], 4'(1 << i), 1'b0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_action"}, 64'(action), 64'd0);
    chk({tag, "_index"}, 64'(index), 64'd0);
    chk({tag, "_mindex"}, 64'(mindex), 64'd0);
    chk({tag, "_din"}, 64'(din), 64'd0);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_prog_addr"}, 64'(prog_addr), 64'd0);
    chk({tag, "_conf_sm"}, 64'(conf_sm), 64'd0);
    chk({tag, "_conf_idx"}, 64'(conf_idx), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      if (!rst && (action != 4'd0 || ack != 4'd0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: cycle %0d action %0h mindex %0h din %0h ack %0h, none expected",
                   cyc_abs - t0, action, mindex, din, ack);
        end else begin
          e = exp_q.pop_front();
          got = pack(cyc_abs, action, e[0] ? index : e[43:39], mindex, din, ack, e[0]);
          if (got !== e) begin
            errors++;
            $display("FAIL scoreboard: got cyc %0d act %0h idx %0h m %0h din %0h ack %0h; expected cyc %0d act %0h idx %0h m %0h din %0h ack %0h",
                     got[79:48] - t0, got[47:44], got[43:39], got[38:37], got[36:5], got[4:1],
                     e[79:48] - t0, e[47:44], e[43:39], e[38:37], e[36:5], e[4:1]);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3:0] ea;
    rst      = 1'b1;
    reload   = 1'b0;
    req      = 4'd0;
    tx_full  = 4'd0;
    req_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    // Default load plus the PROG_LEN=4 / CONF_MASK=0 instance alongside.
    release_reset();
    expect_load();
    for (int r = 0; r < 9; r++) begin
      goto(r);
      if (r == 0) begin
        chk("cyc0_prog_addr", 64'(prog_addr), 64'd0);
        chk("cyc0_ready", 64'(ready), 64'd0);
      end
      ea = (r >= 2 && r <= 5) ? 4'd1 : 4'd0;
      chk("dut2_action", 64'(action2), 64'(ea));
      chk("dut2_ready", 64'(ready2), (r >= 6) ? 64'd1 : 64'd0);
      chk("dut2_ack", 64'(ack2), 64'd0);
      chk("dut2_mindex", 64'(mindex2), 64'd0);
      if (ea == 4'd1) begin
        chk("dut2_index", 64'(index2), 64'(r - 2));
        chk("dut2_din", 64'(din2), 64'(32'h0000B000 + 32'(r - 2)));
      end
    end
    chk("dut2_state", 64'(dbg_state2), 64'd2);
    chk("dut2_conf_sm", 64'(conf_sm2), 64'd0);
    chk("dut2_conf_idx", 64'(conf_idx2), 64'd0);

    goto(53);
    chk("ready_c53", 64'(ready), 64'd0);
    goto(54);
    chk("ready_c54", 64'(ready), 64'd1);
    chk("action_c54", 64'(action), 64'd0);
    chk("state_c54", 64'(dbg_state), 64'd2);

    // Round-robin with all four requesting.
    req = 4'hF;
    for (int n = 0; n < 5; n++) push_grant(55 + n, n % 4);
    goto(59);
    req = 4'h0;

    // Single requester held: alternate-cycle pushes.
    goto(62);
    req = 4'h1;
    push_grant(63, 0);
    push_grant(65, 0);
    push_grant(67, 0);
    goto(68);
    req = 4'h0;

    // Back-pressure on machine 1, then release it.
    goto(70);
    tx_full = 4'b0010;
    req     = 4'b0011;
    push_grant(71, 0);
    push_grant(73, 0);
    goto(74);
    tx_full = 4'b0000;
    push_grant(75, 1);
    push_grant(76, 0);
    goto(76);
    req = 4'h0;

    // Reload pulse: no grant that cycle, then a full reload.
    goto(80);
    chk("queue_before_reload", 64'(exp_q.size()), 64'd0);
    reload = 1'b1;
    req    = 4'hF;
    @(negedge clk);
    reload = 1'b0;
    req    = 4'h0;
    t0     = t0 + 81;
    chk("reload_ready", 64'(ready), 64'd0);
    chk("reload_ack", 64'(ack), 64'd0);
    chk("reload_prog_addr", 64'(prog_addr), 64'd0);
    expect_load();

    // Reset in the middle of the config phase.
    goto(39);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 exp_q.delete();
    chk_all_zero("midreset");
    release_reset();
    expect_load();
    goto(2);
    chk("after_reset_w0_action", 64'(action), 64'd1);
    chk("after_reset_w0_din", 64'(din), 64'h0000A000);
    goto(53);
    chk("after_reset_ready_c53", 64'(ready), 64'd0);
    goto(54);
    chk("after_reset_ready_c54", 64'(ready), 64'd1);
    goto(58);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
